inst_mem_arb: RTL and testbench

//   Two-requester arbiter/sequencer in front of inst_mem. Requester 0 (program loader) and

---
 rtl/inst_mem_arb.sv | 152 +++++++++++++++
 tb/tb_inst_mem_arb.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_arb.sv
// Two-requester round-robin arbiter with burst lock in front of inst_mem.
// It registers one command per cycle and tags reads so that each response returns to the requester that issued it.
module inst_mem_arb #(
    parameter int DWIDTH   = 8,
    parameter int ADDR     = 10,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 16
) (
    input  logic              i_mem_clk,
    input  logic              i_rst_n,
    input  logic              i_req0_valid,
    input  logic              i_req0_web,
    input  logic [ADDR-1:0]   i_req0_addr,
    input  logic [DWIDTH-1:0] i_req0_data,
    input  logic              i_req0_lock,
    input  logic              i_req1_valid,
    input  logic              i_req1_web,
    input  logic [ADDR-1:0]   i_req1_addr,
    input  logic [DWIDTH-1:0] i_req1_data,
    input  logic              i_req1_lock,
    output logic              o_req0_ready,
    output logic              o_req1_ready,
    output logic              o_rsp0_valid,
    output logic [DWIDTH-1:0] o_rsp0_data,
    output logic              o_rsp1_valid,
    output logic [DWIDTH-1:0] o_rsp1_data,
    output logic              o_mem_csb,
    output logic              o_mem_web,
    output logic [ADDR-1:0]   o_mem_read_addr,
    output logic [ADDR-1:0]   o_mem_write_addr,
    output logic [DWIDTH-1:0] o_mem_data,
    input  logic [DWIDTH-1:0] i_mem_data
);
    localparam int CNT_W = $clog2(LOCK_MAX);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt0, gnt1;
    logic              acc, acc_id, acc_web, acc_lock;
    logic [ADDR-1:0]   acc_addr;
    logic [DWIDTH-1:0] acc_data;
    logic              csb_q, web_q;
    logic [ADDR-1:0]   raddr_q, waddr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [RD_LAT:0]   tag_vld_q, tag_id_q;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (i_rst_n) begin
            case (state_q)
                IDLE: begin
                    if (i_req0_valid && i_req1_valid) begin
                        gnt0 = last_grant_q;
                        gnt1 = !last_grant_q;
                    end else begin
                        gnt0 = i_req0_valid;
                        gnt1 = i_req1_valid;
                    end
                end
                LOCK0:   gnt0 = i_req0_valid;
                LOCK1:   gnt1 = i_req1_valid;
                default: ;
            endcase
        end
    end

    assign o_req0_ready = gnt0;
    assign o_req1_ready = gnt1;
    assign acc      = gnt0 | gnt1;
    assign acc_id   = gnt1;
    assign acc_web  = gnt1 ? i_req1_web  : i_req0_web;
    assign acc_lock = gnt1 ? i_req1_lock : i_req0_lock;
    assign acc_addr = gnt1 ? i_req1_addr : i_req0_addr;
    assign acc_data = gnt1 ? i_req1_data : i_req0_data;

    // Reaching LOCK_MAX-1 releases the lock whatever the lock bit says, so a locked requester cannot starve the other.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        if (acc) begin
            last_grant_d = acc_id;
            if (state_q == IDLE) begin
                if (acc_lock) begin
                    state_d = acc_id ? LOCK1 : LOCK0;
                    cnt_d   = CNT_W'(1);
                end
            end else if (!acc_lock || cnt_q == CNT_W'(LOCK_MAX - 1)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_mem_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_ff @(posedge i_mem_clk) begin
        if (!i_rst_n) begin
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (acc) begin
            csb_q   <= 1'b0;
            web_q   <= acc_web;
            raddr_q <= acc_addr;
            waddr_q <= acc_addr;
            wdata_q <= acc_data;
        end else begin
            csb_q <= 1'b1;
            web_q <= 1'b1;
        end
    end

    // Stage 0 loads on accept; stage RD_LAT lines up with inst_mem output data.
    always_ff @(posedge i_mem_clk) begin
        if (!i_rst_n) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[RD_LAT-1:0], acc & acc_web};
            tag_id_q  <= {tag_id_q[RD_LAT-1:0], acc_id};
        end
    end

    assign o_mem_csb        = csb_q;
    assign o_mem_web        = web_q;
    assign o_mem_read_addr  = raddr_q;
    assign o_mem_write_addr = waddr_q;
    assign o_mem_data       = wdata_q;
    assign o_rsp0_valid     = tag_vld_q[RD_LAT] & ~tag_id_q[RD_LAT];
    assign o_rsp1_valid     = tag_vld_q[RD_LAT] &  tag_id_q[RD_LAT];
    assign o_rsp0_data      = i_mem_data;
    assign o_rsp1_data      = i_mem_data;
endmodule

// File: tb/tb_inst_mem_arb.sv
// Directed bench for inst_mem_arb with a behavioural inst_mem model (read latency 1).
module tb_inst_mem_arb;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       v0, web0, l0, v1, web1, l1;
    logic [9:0] a0, a1;
    logic [7:0] d0, d1;
    logic       rdy0, rdy1, rv0, rv1;
    logic [7:0] rd0, rd1;
    logic       csb, web;
    logic [9:0] raddr, waddr;
    logic [7:0] mdata, mem_q;
    logic [7:0] mem [1024];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!csb) begin
            if (!web) mem[waddr] <= mdata;
            else      mem_q <= mem[raddr];
        end
    end

    inst_mem_arb #(.DWIDTH(8), .ADDR(10), .RD_LAT(1), .LOCK_MAX(16)) dut (
        .i_mem_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(v0), .i_req0_web(web0), .i_req0_addr(a0), .i_req0_data(d0), .i_req0_lock(l0),
        .i_req1_valid(v1), .i_req1_web(web1), .i_req1_addr(a1), .i_req1_data(d1), .i_req1_lock(l1),
        .o_req0_ready(rdy0), .o_req1_ready(rdy1),
        .o_rsp0_valid(rv0), .o_rsp0_data(rd0), .o_rsp1_valid(rv1), .o_rsp1_data(rd1),
        .o_mem_csb(csb), .o_mem_web(web), .o_mem_read_addr(raddr), .o_mem_write_addr(waddr),
        .o_mem_data(mdata), .i_mem_data(mem_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        v0 = 1'b1; web0 = 1'b1; a0 = '0; d0 = '0; l0 = 1'b0;
        v1 = 1'b1; web1 = 1'b1; a1 = '0; d1 = '0; l1 = 1'b0;
        nxt();
        nxt();
        #1;
        chk("rst_ready0", 32'(rdy0), 32'd0);
        chk("rst_ready1", 32'(rdy1), 32'd0);
        chk("rst_csb", 32'(csb), 32'd1);
        chk("rst_web", 32'(web), 32'd1);
        chk("rst_raddr", 32'(raddr), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_mdata", 32'(mdata), 32'd0);
        chk("rst_rsp0", 32'(rv0), 32'd0);
        chk("rst_rsp1", 32'(rv1), 32'd0);

        // first cycle out of reset: tie goes to requester 0
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready0", 32'(rdy0), 32'd1);
        chk("post_rst_ready1", 32'(rdy1), 32'd0);
        nxt();
        v0 = 1'b0; v1 = 1'b0;
        #1;
        chk("first_rd_csb", 32'(csb), 32'd0);
        chk("first_rd_web", 32'(web), 32'd1);
        chk("first_rd_rsp_early", 32'(rv0), 32'd0);
        nxt();
        chk("first_rd_rsp0", 32'(rv0), 32'd1);
        chk("first_rd_csb_idle", 32'(csb), 32'd1);
        nxt();
        chk("first_rd_rsp0_gone", 32'(rv0), 32'd0);

        // two writes from req0, then req1 reads one back
        v0 = 1'b1; web0 = 1'b0; a0 = 10'd20; d0 = 8'h20;
        #1;
        chk("wr_ready0", 32'(rdy0), 32'd1);
        nxt();
        a0 = 10'd21; d0 = 8'h21;
        #1;
        chk("wr1_csb", 32'(csb), 32'd0);
        chk("wr1_web", 32'(web), 32'd0);
        chk("wr1_waddr", 32'(waddr), 32'd20);
        chk("wr1_data", 32'(mdata), 32'h20);
        nxt();
        v0 = 1'b0;
        v1 = 1'b1; web1 = 1'b1; a1 = 10'd20;
        #1;
        chk("wr2_csb", 32'(csb), 32'd0);
        chk("wr2_web", 32'(web), 32'd0);
        chk("wr2_waddr", 32'(waddr), 32'd21);
        chk("wr2_data", 32'(mdata), 32'h21);
        chk("rd1_ready1", 32'(rdy1), 32'd1);
        nxt();
        v1 = 1'b0;
        #1;
        chk("rd1_csb", 32'(csb), 32'd0);
        chk("rd1_web", 32'(web), 32'd1);
        chk("rd1_raddr", 32'(raddr), 32'd20);
        chk("rd1_rsp_early", 32'(rv1), 32'd0);
        nxt();
        chk("rd1_rsp1", 32'(rv1), 32'd1);
        chk("rd1_rsp0", 32'(rv0), 32'd0);
        chk("rd1_data", 32'(rd1), 32'h20);
        nxt();
        chk("rd1_rsp1_gone", 32'(rv1), 32'd0);

        // req1 fills 0..3 with C0..C3, then both requesters read and alternate
        for (int i = 0; i < 4; i++) begin
            v1 = 1'b1; web1 = 1'b0; a1 = 10'(i); d1 = 8'(8'hC0 + i);
            nxt();
        end
        v1 = 1'b0;
        for (int j = 0; j < 6; j++) begin
            v0 = (j < 4); web0 = 1'b1;
            v1 = (j < 4); web1 = 1'b1;
            a0 = (j == 0) ? 10'd0 : ((j <= 2) ? 10'd2 : 10'd4);
            a1 = (j <= 1) ? 10'd1 : 10'd3;
            #1;
            if (j < 4) begin
                chk("rr_ready0", 32'(rdy0), 32'((j % 2) == 0));
                chk("rr_ready1", 32'(rdy1), 32'((j % 2) == 1));
            end
            if (j >= 2) begin
                chk("rr_rsp0", 32'(rv0), 32'(((j - 2) % 2) == 0));
                chk("rr_rsp1", 32'(rv1), 32'(((j - 2) % 2) == 1));
                chk("rr_data", 32'(rd0), 32'(8'hC0 + j - 2));
            end else begin
                chk("rr_rsp_none", 32'({rv0, rv1}), 32'd0);
            end
            nxt();
        end
        v0 = 1'b0; v1 = 1'b0;

        // burst lock: req0 locks, one idle cycle at c=5, req1 valid throughout
        do_reset();
        for (int c = 0; c < 20; c++) begin
            v0 = (c != 5); web0 = 1'b1; l0 = 1'b1; a0 = 10'(100 + c);
            v1 = 1'b1; web1 = 1'b1; l1 = 1'b0; a1 = 10'd200;
            #1;
            chk("lock_ready0", 32'(rdy0), 32'(c != 5 && c != 17));
            chk("lock_ready1", 32'(rdy1), 32'(c == 17));
            nxt();
        end
        v0 = 1'b0; v1 = 1'b0; l0 = 1'b0;

        // write then immediate read of the same address
        do_reset();
        v0 = 1'b1; web0 = 1'b0; a0 = 10'd5; d0 = 8'hA5;
        nxt();
        web0 = 1'b1;
        nxt();
        v0 = 1'b0;
        #1;
        chk("raw_rsp_early", 32'(rv0), 32'd0);
        nxt();
        chk("raw_rsp0", 32'(rv0), 32'd1);
        chk("raw_data", 32'(rd0), 32'hA5);

        // reset one cycle after a read accept cancels its response
        v1 = 1'b1; web1 = 1'b1; a1 = 10'd20;
        nxt();
        v1 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("inflight_ready_in_rst", 32'(rdy1), 32'd0);
        nxt();
        chk("inflight_rsp1", 32'(rv1), 32'd0);
        chk("inflight_csb", 32'(csb), 32'd1);
        rst_n = 1'b1;
        nxt();
        chk("inflight_rsp_after", 32'({rv0, rv1}), 32'd0);
        v0 = 1'b1; v1 = 1'b1;
        #1;
        chk("inflight_idle_ready0", 32'(rdy0), 32'd1);
        chk("inflight_idle_ready1", 32'(rdy1), 32'd0);
        v0 = 1'b0; v1 = 1'b0;
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
